// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared state encoding and ns-to-cycle conversion for the ROM streamer.
`timescale 1ns/1ps
package rom_stream_pkg;
    typedef enum logic [2:0] {IDLE, SEL_CHUNK, SETUP, HOLD, DRIVE_LO, WAIT_DATA, OUTPUT} state_t;

    function automatic int ns_to_cycles(input int ns, input int period);
        int c;
        c = (ns + period - 1) / period;
        return (c < 1) ? 1 : c;
    endfunction
endpackage

// File: rtl/rom_wait_timer.sv
// rom_wait_timer: down-counter; expire_out is high during the last cycle of a loaded wait.
`timescale 1ns/1ps
module rom_wait_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load_in,
    input  logic [CNT_W-1:0] value_in,
    output logic             expire_out
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_in ? value_in : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) cnt_q <= '0;
        else           cnt_q <= cnt_d;

    assign expire_out = cnt_q == CNT_W'(1);
endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a window of a latch-multiplexed parallel ROM onto a valid/ready port,
// caching upper address chunks so unchanged ones are not re-latched.
`timescale 1ns/1ps
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int PERIOD_NS     = 10,
    parameter int BUS_W         = 8,
    parameter int ADDR_W        = 16,
    parameter int SETUP_NS      = 250,
    parameter int HOLD_NS       = 250,
    parameter int DATA_DELAY_NS = 250,
    localparam int NUM_LATCH    = ADDR_W / BUS_W - 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    base_addr_in,
    input  logic [ADDR_W:0]      count_in,
    input  logic                 abort_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [BUS_W-1:0]     rom_addr_out,
    output logic [NUM_LATCH-1:0] rom_latch_out,
    input  logic [BUS_W-1:0]     rom_data_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [BUS_W-1:0]     data_out,
    output logic [ADDR_W-1:0]    addr_out
);
    localparam int SETUP_C = ns_to_cycles(SETUP_NS, PERIOD_NS);
    localparam int HOLD_C  = ns_to_cycles(HOLD_NS, PERIOD_NS);
    localparam int DELAY_C = ns_to_cycles(DATA_DELAY_NS, PERIOD_NS);
    localparam int MAX_C   = SETUP_C > HOLD_C ? (SETUP_C > DELAY_C ? SETUP_C : DELAY_C)
                                              : (HOLD_C > DELAY_C ? HOLD_C : DELAY_C);
    localparam int CNT_W   = $clog2(MAX_C + 1);
    localparam int KW      = NUM_LATCH > 1 ? $clog2(NUM_LATCH) : 1;

    state_t                         state_q, state_d;
    logic [KW-1:0]                  k_q, k_d;
    logic [ADDR_W-1:0]              cur_q, cur_d, addr_q, addr_d;
    logic [ADDR_W:0]                rem_q, rem_d;
    logic [NUM_LATCH*BUS_W-1:0]     cache_q, cache_d;
    logic [NUM_LATCH-1:0]           vld_q, vld_d, latch_q, latch_d, k_oh;
    logic [BUS_W-1:0]               rom_addr_q, rom_addr_d, data_q, data_d, chunk, cached;
    logic                           valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic                           tmr_load, expire, hit;
    logic [CNT_W-1:0]               tmr_val;

    rom_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_in    (tmr_load),
        .value_in   (tmr_val),
        .expire_out (expire)
    );

    // Latch k holds address chunk k+1; chunk 0 is driven directly during the data phase.
    assign k_oh   = NUM_LATCH'(1) << k_q;
    assign chunk  = cur_q[(int'(k_q) + 1) * BUS_W +: BUS_W];
    assign cached = cache_q[int'(k_q) * BUS_W +: BUS_W];
    assign hit    = |(vld_q & k_oh) && cached == chunk;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        cache_d    = cache_q;
        vld_d      = vld_q;
        rom_addr_d = rom_addr_q;
        latch_d    = latch_q;
        data_d     = data_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = CNT_W'(SETUP_C);
        if (abort_in) begin
            state_d = IDLE;
            latch_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            vld_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start_in) begin
                    cur_d   = base_addr_in;
                    rem_d   = count_in;
                    k_d     = KW'(NUM_LATCH - 1);
                    done_d  = count_in == '0;
                    busy_d  = count_in != '0;
                    state_d = count_in == '0 ? IDLE : SEL_CHUNK;
                end
                SEL_CHUNK: if (hit) begin
                    state_d = k_q == '0 ? DRIVE_LO : SEL_CHUNK;
                    k_d     = k_q == '0 ? k_q : k_q - 1'b1;
                end else begin
                    rom_addr_d = chunk;
                    tmr_load   = 1'b1;
                    state_d    = SETUP;
                end
                SETUP: if (expire) begin
                    latch_d  = k_oh;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_C);
                    state_d  = HOLD;
                end
                HOLD: if (expire) begin
                    latch_d = '0;
                    cache_d[int'(k_q) * BUS_W +: BUS_W] = chunk;
                    vld_d   = vld_q | k_oh;
                    state_d = k_q == '0 ? DRIVE_LO : SEL_CHUNK;
                    k_d     = k_q == '0 ? k_q : k_q - 1'b1;
                end
                DRIVE_LO: begin
                    rom_addr_d = cur_q[BUS_W-1:0];
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(DELAY_C);
                    state_d    = WAIT_DATA;
                end
                WAIT_DATA: if (expire) begin
                    data_d  = rom_data_in;
                    addr_d  = cur_q;
                    valid_d = 1'b1;
                    state_d = OUTPUT;
                end
                OUTPUT: if (ready_in) begin
                    valid_d = 1'b0;
                    cur_d   = cur_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    done_d  = rem_q == (ADDR_W + 1)'(1);
                    busy_d  = rem_q != (ADDR_W + 1)'(1);
                    state_d = rem_q == (ADDR_W + 1)'(1) ? IDLE : SEL_CHUNK;
                    k_d     = KW'(NUM_LATCH - 1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cur_q      <= '0;
            rem_q      <= '0;
            cache_q    <= '0;
            vld_q      <= '0;
            rom_addr_q <= '0;
            latch_q    <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            cache_q    <= cache_d;
            vld_q      <= vld_d;
            rom_addr_q <= rom_addr_d;
            latch_q    <= latch_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign rom_addr_out  = rom_addr_q;
    assign rom_latch_out = latch_q;
    assign valid_out     = valid_q;
    assign data_out      = data_q;
    assign addr_out      = addr_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed stimulus with an expected-word queue checked by a handshake monitor,
// against a latch-based ROM model returning addr[7:0]^addr[15:8].
`timescale 1ns/1ps
module tb_rom_stream_reader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [15:0] base = '0;
    logic [16:0] count = '0;
    logic        busy, done, valid;
    logic [7:0]  rom_addr, rom_data, data;
    logic [0:0]  latch;
    logic [15:0] addr;
    logic [7:0]  hi = '0;
    logic [23:0] exp_q[$];
    int          errors = 0, checks = 0, latch_cnt = 0, done_cnt = 0, valid_cnt = 0;

    always #5 clk = ~clk;

    rom_stream_reader dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .base_addr_in(base), .count_in(count),
        .abort_in(abort), .busy_out(busy), .done_out(done), .rom_addr_out(rom_addr),
        .rom_latch_out(latch), .rom_data_in(rom_data), .valid_out(valid), .ready_in(ready),
        .data_out(data), .addr_out(addr)
    );

    always @(posedge latch[0]) begin
        hi = rom_addr;
        latch_cnt++;
    end
    assign rom_data = rom_addr ^ hi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (valid) valid_cnt++;
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) chk("unexpected word", {16'h0, addr}, 32'hFFFF_FFFF);
            else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("word addr", addr, e[23:8]);
                chk("word data", data, e[7:0]);
            end
        end
    end

    function automatic bit cond(input int c);
        return c == 0 ? done : c == 1 ? latch[0] : c == 2 ? !latch[0] : valid;
    endfunction

    task automatic wait_for(input int c, input string nm);
        int n = 0;
        while (!cond(c) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!cond(c)) chk({"timeout ", nm}, 0, 1);
    endtask

    task automatic start_txn(input logic [15:0] b, input logic [16:0] cnt, input bit push);
        @(posedge clk);
        #1;
        base  = b;
        count = cnt;
        start = 1'b1;
        for (int i = 0; i < int'(cnt) && push; i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            exp_q.push_back({a, a[7:0] ^ a[15:8]});
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lc, dc, vc, bad;
        logic [7:0]  sd, sr;
        logic [15:0] sa;
        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, done, valid, latch, rom_addr, data, addr}, 0);
        rst_n = 1'b1;

        // 4 words across a high-chunk boundary
        lc = latch_cnt; dc = done_cnt;
        start_txn(16'h12FE, 17'd4, 1'b1);
        chk("busy after start", busy, 1);
        wait_for(0, "done t1");
        repeat (3) @(negedge clk);
        chk("t1 latches", latch_cnt - lc, 2);
        chk("t1 last high chunk", hi, 8'h13);
        chk("t1 done pulses", done_cnt - dc, 1);
        chk("t1 queue empty", exp_q.size(), 0);
        chk("t1 busy cleared", busy, 0);

        // zero-length window
        lc = latch_cnt; dc = done_cnt; vc = valid_cnt;
        start_txn(16'h4000, 17'd0, 1'b1);
        chk("count0 done", done, 1);
        repeat (5) @(negedge clk);
        chk("count0 done once", done_cnt - dc, 1);
        chk("count0 latches", latch_cnt - lc, 0);
        chk("count0 valid", valid_cnt - vc, 0);

        // wrap through 0xFFFF re-latches the high chunk twice
        lc = latch_cnt;
        start_txn(16'hFFFF, 17'd2, 1'b1);
        wait_for(0, "done wrap");
        repeat (2) @(negedge clk);
        chk("wrap latches", latch_cnt - lc, 2);
        chk("wrap queue empty", exp_q.size(), 0);

        // back-pressure: word must hold and no ROM access may start
        ready = 1'b0;
        lc = latch_cnt;
        start_txn(16'h1234, 17'd2, 1'b1);
        wait_for(3, "valid bp");
        sd = data; sa = addr; sr = rom_addr; bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (!valid || data !== sd || addr !== sa || rom_addr !== sr || latch !== 1'b0) bad++;
        end
        chk("bp stable", bad, 0);
        chk("bp latches", latch_cnt - lc, 1);
        @(posedge clk);
        #1 ready = 1'b1;
        wait_for(0, "done bp");
        repeat (2) @(negedge clk);
        chk("bp queue empty", exp_q.size(), 0);

        // abort during HOLD, then restart on a previously cached chunk
        dc = done_cnt;
        start_txn(16'h5600, 17'd1, 1'b0);
        wait_for(1, "latch rise abort");
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort latch", latch, 0);
        chk("abort busy", busy, 0);
        chk("abort valid", valid, 0);
        repeat (5) @(negedge clk);
        chk("abort no done", done_cnt - dc, 0);
        lc = latch_cnt;
        start_txn(16'h1200, 17'd1, 1'b1);
        wait_for(0, "done restart");
        repeat (2) @(negedge clk);
        chk("restart relatch", latch_cnt - lc, 1);
        chk("restart queue empty", exp_q.size(), 0);

        // async reset during WAIT_DATA
        start_txn(16'h3345, 17'd1, 1'b0);
        wait_for(1, "latch rise rst");
        wait_for(2, "latch fall rst");
        repeat (5) @(posedge clk);
        #3;
        chk("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", {busy, done, valid, latch, rom_addr, data, addr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lc = latch_cnt;
        start_txn(16'h3345, 17'd1, 1'b1);
        wait_for(0, "done post-reset");
        repeat (2) @(negedge clk);
        chk("post-reset relatch", latch_cnt - lc, 1);
        chk("final queue empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
